// File: rtl/acorn128_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : acorn128_ctrl_if
// Description : Host-side bundle for the ACORN-128 sequencer. Carries the
//               operation request (start, key, iv, lengths), the shared
//               AD/plaintext bit stream with its valid/ready handshake, the
//               ciphertext bit stream and the status/tag results.
//               master : host side (drives request and din stream)
//               slave  : sequencer side (drives ready, ct, status, tag)
// Revision    : 1.0 - initial release
// ============================================================================
interface acorn128_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [127:0]     key;
  logic [127:0]     iv;
  logic [LEN_W-1:0] ad_len;
  logic [LEN_W-1:0] msg_len;
  logic             din_bit;
  logic             din_valid;
  logic             din_ready;
  logic             ct_bit;
  logic             ct_valid;
  logic             busy;
  logic             done;
  logic [127:0]     tag;

  modport master (
    output start, key, iv, ad_len, msg_len, din_bit, din_valid,
    input  din_ready, ct_bit, ct_valid, busy, done, tag
  );

  modport slave (
    input  start, key, iv, ad_len, msg_len, din_bit, din_valid,
    output din_ready, ct_bit, ct_valid, busy, done, tag
  );
endinterface
`default_nettype wire

// File: rtl/acorn128_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : acorn128_ctrl
// Description : Bit-serial sequencer for the ACORN-128 one-bit-per-cycle
//               state-update datapath. Walks CLR, INIT, AD, ADPAD, ENC,
//               ENCPAD and FIN, producing per-step ca/cb/message bits,
//               returning ciphertext bits and collecting the 128-bit tag.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               host      - acorn128_ctrl_if.slave (request, din stream,
//                           ct stream, busy/done, tag)
//               ks_in     - datapath keystream bit for the current step
//               upd_en    - datapath performs one update step
//               st_clr    - datapath state cleared this cycle
//               ca_out, cb_out, mbit_out - step control bits (0 when idle)
// Revision    : 1.0 - initial release
// ============================================================================
module acorn128_ctrl #(
  parameter int LEN_W      = 16,
  parameter int INIT_STEPS = 1792,
  parameter int PAD_STEPS  = 256,
  parameter int FIN_STEPS  = 768
) (
  input  logic            clk,
  input  logic            rst,
  acorn128_ctrl_if.slave  host,
  input  logic            ks_in,
  output logic            upd_en,
  output logic            st_clr,
  output logic            ca_out,
  output logic            cb_out,
  output logic            mbit_out
);

  localparam int CNT_W = (LEN_W > 11) ? LEN_W : 11;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_STEPS - 1);
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(PAD_STEPS - 1);
  localparam logic [CNT_W-1:0] FIN_LAST  = CNT_W'(FIN_STEPS - 1);
  localparam logic [CNT_W-1:0] TAG_FIRST = CNT_W'(FIN_STEPS - 128);
  localparam logic [CNT_W-1:0] HALF_PAD  = CNT_W'(128);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLR    = 4'd1,
    S_INIT   = 4'd2,
    S_AD     = 4'd3,
    S_ADPAD  = 4'd4,
    S_ENC    = 4'd5,
    S_ENCPAD = 4'd6,
    S_FIN    = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       iv_q, iv_d;
  logic [LEN_W-1:0]   ad_len_q, ad_len_d;
  logic [LEN_W-1:0]   msg_len_q, msg_len_d;
  logic [127:0]       tag_q, tag_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               init_mbit;
  logic               ready;
  logic               ct_vld;
  logic               done_p;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Loading order: key bits, then IV bits, one inverted key[0], then the key
  // repeated for the rest of initialization.
  always_comb begin
    init_mbit = key_q[cnt_q[6:0]];
    if (cnt_q >= CNT_W'(128) && cnt_q < CNT_W'(256)) begin
      init_mbit = iv_q[cnt_q[6:0]];
    end else if (cnt_q == CNT_W'(256)) begin
      init_mbit = ~key_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      iv_q      <= '0;
      ad_len_q  <= '0;
      msg_len_q <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
      ad_len_q  <= ad_len_d;
      msg_len_q <= msg_len_d;
      tag_q     <= tag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    iv_d      = iv_q;
    ad_len_d  = ad_len_q;
    msg_len_d = msg_len_q;
    tag_d     = tag_q;
    upd_en    = 1'b0;
    st_clr    = 1'b0;
    ca_out    = 1'b0;
    cb_out    = 1'b0;
    mbit_out  = 1'b0;
    ready     = 1'b0;
    ct_vld    = 1'b0;
    done_p    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (host.start) begin
          key_d     = host.key;
          iv_d      = host.iv;
          ad_len_d  = host.ad_len;
          msg_len_d = host.msg_len;
          tag_d     = '0;
          cnt_d     = '0;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        st_clr  = 1'b1;
        cnt_d   = '0;
        state_d = S_INIT;
      end
      S_INIT: begin
        upd_en   = 1'b1;
        ca_out   = 1'b1;
        cb_out   = 1'b1;
        mbit_out = init_mbit;
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = (ad_len_q == '0) ? S_ADPAD : S_AD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_AD: begin
        ready    = 1'b1;
        upd_en   = host.din_valid;
        ca_out   = host.din_valid;
        cb_out   = host.din_valid;
        mbit_out = host.din_valid & host.din_bit;
        if (host.din_valid) begin
          if (cnt_inc == CNT_W'(ad_len_q)) begin
            cnt_d   = '0;
            state_d = S_ADPAD;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_ADPAD, S_ENCPAD: begin
        // Padding: a single 1 bit, ca held for the first half, cb tells the
        // two padding phases apart.
        upd_en   = 1'b1;
        mbit_out = (cnt_q == '0);
        ca_out   = (cnt_q < HALF_PAD);
        cb_out   = (state_q == S_ADPAD);
        if (cnt_q == PAD_LAST) begin
          cnt_d = '0;
          if (state_q == S_ENCPAD) begin
            state_d = S_FIN;
          end else begin
            state_d = (msg_len_q == '0) ? S_ENCPAD : S_ENC;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ENC: begin
        ready    = 1'b1;
        ct_vld   = host.din_valid;
        upd_en   = host.din_valid;
        ca_out   = host.din_valid;
        mbit_out = host.din_valid & host.din_bit;
        if (host.din_valid) begin
          if (cnt_inc == CNT_W'(msg_len_q)) begin
            cnt_d   = '0;
            state_d = S_ENCPAD;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_FIN: begin
        upd_en = 1'b1;
        ca_out = 1'b1;
        cb_out = 1'b1;
        // Tag bits arrive in order 0..127; shifting in from the top leaves
        // the first captured bit at tag[0] after the last step.
        if (cnt_q >= TAG_FIRST) begin
          tag_d = {ks_in, tag_q[127:1]};
        end
        if (cnt_q == FIN_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        done_p  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign host.din_ready = ready;
  assign host.ct_valid  = ct_vld;
  assign host.ct_bit    = ct_vld & (host.din_bit ^ ks_in);
  assign host.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign host.done      = done_p;
  assign host.tag       = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_acorn128_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_acorn128_ctrl
// Description : Bench for acorn128_ctrl. A toy 64-bit datapath stands in for
//               the ACORN state so that ks_in depends on every control bit
//               the sequencer has issued. Expected per-step control triples,
//               ciphertext bits and the tag are built from the sequencing
//               rules before each run and consumed as the DUT steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acorn128_ctrl;

  localparam int INIT = 1792;
  localparam int PAD  = 256;
  localparam int FIN  = 768;

  logic clk = 1'b0;
  logic rst;
  logic ks_in, upd_en, st_clr, ca_out, cb_out, mbit_out;
  logic [63:0] dp_s = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_ctl[$];
  bit         exp_ct[$];

  acorn128_ctrl_if #(.LEN_W(16)) bus ();

  acorn128_ctrl #(
    .LEN_W(16), .INIT_STEPS(INIT), .PAD_STEPS(PAD), .FIN_STEPS(FIN)
  ) dut (
    .clk(clk), .rst(rst), .host(bus), .ks_in(ks_in),
    .upd_en(upd_en), .st_clr(st_clr), .ca_out(ca_out),
    .cb_out(cb_out), .mbit_out(mbit_out)
  );

  always #5 clk = ~clk;

  function automatic logic ksf(input logic [63:0] s);
    return s[3] ^ s[17] ^ (s[29] & s[41]) ^ s[55] ^ s[63];
  endfunction

  function automatic logic [63:0] nxt(input logic [63:0] s, input logic ca,
                                      input logic cb, input logic m);
    logic fb;
    fb = s[0] ^ s[22] ^ (s[35] & s[8]) ^ m ^ (ca & s[50]) ^ (cb & ksf(s));
    return {fb, s[63:1]};
  endfunction

  // Stand-in datapath driven by the DUT's control outputs.
  assign ks_in = ksf(dp_s);
  always @(posedge clk) begin
    if (st_clr)      dp_s <= '0;
    else if (upd_en) dp_s <= nxt(dp_s, ca_out, cb_out, mbit_out);
  end

  task automatic check(input string name, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // {upd_en, st_clr, ca, cb, mbit, din_ready, ct_valid, busy, done}
  function automatic logic [8:0] obs_vec();
    return {upd_en, st_clr, ca_out, cb_out, mbit_out,
            bus.din_ready, bus.ct_valid, bus.busy, bus.done};
  endfunction

  task automatic run_op(input logic [127:0] k, input logic [127:0] v,
                        input int adl, input int msgl,
                        input bit [63:0] adb, input bit [63:0] msgb,
                        input int exp_total, input bit toggle, input bit poke,
                        input int rst_at, output logic [127:0] tag_out);
    int n, enc_lo, kk, cyc, upd_cnt;
    logic [63:0] s;
    logic [127:0] etag;
    logic ks, in_ad, in_enc, exp_upd, exp_ctv;
    logic [2:0] trip;

    // Expected control sequence, ciphertext and tag.
    exp_ctl.delete();
    exp_ct.delete();
    for (int i = 0; i < INIT; i++) begin
      logic mb;
      if (i < 128)       mb = k[i];
      else if (i < 256)  mb = v[i-128];
      else if (i == 256) mb = ~k[0];
      else               mb = k[i%128];
      exp_ctl.push_back({2'b11, mb});
    end
    for (int i = 0; i < adl; i++)  exp_ctl.push_back({2'b11, adb[i]});
    for (int i = 0; i < PAD; i++)  exp_ctl.push_back({i < 128, 1'b1, i == 0});
    for (int i = 0; i < msgl; i++) exp_ctl.push_back({2'b10, msgb[i]});
    for (int i = 0; i < PAD; i++)  exp_ctl.push_back({i < 128, 1'b0, i == 0});
    for (int i = 0; i < FIN; i++)  exp_ctl.push_back(3'b110);
    n = exp_ctl.size();
    enc_lo = INIT + adl + PAD;
    s = '0;
    etag = '0;
    for (int i = 0; i < n; i++) begin
      ks = ksf(s);
      if (i >= enc_lo && i < enc_lo + msgl) exp_ct.push_back(msgb[i-enc_lo] ^ ks);
      if (i >= n - 128) etag[i-(n-128)] = ks;
      trip = exp_ctl[i];
      s = nxt(s, trip[2], trip[1], trip[0]);
    end

    // Start cycle, seen while still idle.
    bus.start = 1'b1; bus.key = k; bus.iv = v;
    bus.ad_len = 16'(adl); bus.msg_len = 16'(msgl);
    bus.din_valid = 1'b0; bus.din_bit = 1'b0;
    @(negedge clk);
    check("idle_before_start", 128'(obs_vec()), 128'(9'b0));
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("clr_cycle", 128'(obs_vec()), 128'(9'b0_1_000_0_0_1_0));
    @(posedge clk); #1;

    kk = 0; cyc = 0; upd_cnt = 0;
    while (kk < n && cyc < 20000) begin
      in_ad  = (kk >= INIT) && (kk < INIT + adl);
      in_enc = (kk >= enc_lo) && (kk < enc_lo + msgl);
      bus.din_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.din_bit   = in_ad ? adb[kk-INIT] : in_enc ? msgb[kk-enc_lo]
                                           : 1'($urandom_range(1));
      bus.start     = poke && in_enc;
      if (kk == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", 128'({obs_vec(), bus.ct_bit}), 128'(10'b0));
        check("abort_tag", bus.tag, 128'b0);
        @(posedge clk); #1;
        tag_out = bus.tag;
        return;
      end
      @(negedge clk);
      exp_upd = (in_ad || in_enc) ? bus.din_valid : 1'b1;
      trip    = exp_upd ? exp_ctl.pop_front() : 3'b000;
      exp_ctv = in_enc && bus.din_valid;
      check($sformatf("step%0d", kk), 128'(obs_vec()),
            128'({exp_upd, 1'b0, trip, in_ad || in_enc, exp_ctv, 2'b10}));
      if (exp_ctv) check($sformatf("ct_step%0d", kk), 128'(bus.ct_bit),
                         128'(exp_ct.pop_front()));
      if (upd_en) upd_cnt++;
      if (exp_upd) kk++;
      cyc++;
      @(posedge clk); #1;
    end
    check("steps_completed", 128'(kk), 128'(n));

    bus.start = poke; bus.din_valid = 1'b0;
    @(negedge clk);
    check("done_cycle", 128'(obs_vec()), 128'(9'b0_0_000_0_0_0_1));
    check("upd_count", 128'(upd_cnt), 128'(exp_total));
    check("tag", bus.tag, etag);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_after_done", 128'(obs_vec()), 128'(9'b0));
    check("tag_hold", bus.tag, etag);
    @(posedge clk); #1;
    tag_out = bus.tag;
  endtask

  initial begin
    logic [127:0] kv, krnd, tag_a, tag_b, tag_c, tag_d;
    for (int i = 0; i < 16; i++) kv[8*i +: 8] = 8'(i);
    krnd = {$urandom, $urandom, $urandom, $urandom};

    rst = 1'b1; bus.start = 1'b0; bus.key = '0; bus.iv = '0;
    bus.ad_len = '0; bus.msg_len = '0; bus.din_bit = 1'b0; bus.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", 128'({obs_vec(), bus.ct_bit}), 128'(10'b0));
    check("reset_tag", bus.tag, 128'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Empty AD and message.
    run_op('0, '0, 0, 0, '0, '0, 3072, 1'b0, 1'b0, -1, tag_a);
    // 8 AD bits and 8 message bits, valid every cycle.
    run_op(kv, kv, 8, 8, 64'hB5, 64'h3C, 3088, 1'b0, 1'b0, -1, tag_b);
    // Same with valid toggling and stray start pulses in ENC and DONE.
    run_op(kv, kv, 8, 8, 64'hB5, 64'h3C, 3088, 1'b1, 1'b1, -1, tag_c);
    check("stall_tag_equal", tag_c, tag_b);
    // Abort during INIT, then a clean run.
    run_op(krnd, ~krnd, 3, 5, 64'h5, 64'h16, 3080, 1'b0, 1'b0, 500, tag_d);
    run_op(krnd, ~krnd, 3, 5, 64'h5, 64'h16, 3080, 1'b1, 1'b0, -1, tag_d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
